inject_ctrl: RTL and testbench

Local-node injection/ejection controller for the bufferless age-arbitrated router (`brouter`). It sits between the node's core interface and router port 4. It queues core flits in a small FIFO and forms the port-4 control word (valid, dest, src, age). It injects the head flit only in cycles where the router's combinational `port4_ready` permits, and registers flits the router delivers on port 4 for the core. It also tracks head-of-line starvation so the node can be throttled.

---
 rtl/inject_ctrl.sv | 106 ++++++++++
 tb/tb_inject_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inject_ctrl.sv
// Local-node injection/ejection controller for brouter port 4: queues core flits,
// presents the head flit when the router permits, and registers ejected flits.
`ifndef DATA_W
`define DATA_W    16
`define CONTROL_W 17
`define VALID_F   0
`define DEST_F    4:1
`define SRC_F     8:5
`define AGE_F     16:9
`endif

module inject_ctrl #(
   parameter logic [3:0] addr         = 4'b0101,
   parameter int         DEPTH        = 4,
   parameter int         AGE_W        = 8,
   parameter int         STARVE_LIMIT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [3:0]             enq_dest,
   input  logic [`DATA_W-1:0]     enq_data,
   input  logic                   port4_ready,
   output logic [`CONTROL_W-1:0]  port4_ci,
   output logic [`DATA_W-1:0]     port4_di,
   input  logic [`CONTROL_W-1:0]  port4_co,
   input  logic [`DATA_W-1:0]     port4_do,
   output logic                   ej_valid,
   output logic [`CONTROL_W-1:0]  ej_ctrl,
   output logic [`DATA_W-1:0]     ej_data,
   output logic                   starved,
   output logic [15:0]            inj_count
);

   localparam int          PW    = $clog2(DEPTH);
   localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

   logic [PW:0]         wr_ptr, rd_ptr;
   logic [3:0]          dest_mem [DEPTH];
   logic [`DATA_W-1:0]  data_mem [DEPTH];
   logic [AGE_W-1:0]    wait_cnt;
   logic [15:0]         blk_cnt, blk_nxt;
   logic                empty, full, push, fire;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign enq_ready = ~full;
   assign push      = enq_valid & ~full;
   assign fire      = ~empty & port4_ready;

   // Storage is deliberately left out of reset; the pointers alone define occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_ptr[PW-1:0]] <= enq_dest;
         data_mem[wr_ptr[PW-1:0]] <= enq_data;
      end
   end

   always_comb begin
      port4_ci = '0;
      if (fire) begin
         port4_ci[`VALID_F] = 1'b1;
         port4_ci[`DEST_F]  = dest_mem[rd_ptr[PW-1:0]];
         port4_ci[`SRC_F]   = addr;
         port4_ci[`AGE_F]   = wait_cnt;
      end
   end

   assign port4_di = empty ? '0 : data_mem[rd_ptr[PW-1:0]];

   always_comb begin
      blk_nxt = blk_cnt;
      if (empty || fire)        blk_nxt = '0;
      else if (blk_cnt != '1)   blk_nxt = blk_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wait_cnt  <= '0;
         blk_cnt   <= '0;
         starved   <= 1'b0;
         inj_count <= '0;
         ej_valid  <= 1'b0;
         ej_ctrl   <= '0;
         ej_data   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (fire) begin
            rd_ptr    <= rd_ptr + 1'b1;
            inj_count <= inj_count + 16'd1;
         end
         // Age counts cycles at the head; a pop hands a fresh head a zero stamp.
         if (empty || fire)       wait_cnt <= '0;
         else if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
         blk_cnt  <= blk_nxt;
         starved  <= (blk_nxt >= LIMIT);
         ej_valid <= port4_co[`VALID_F];
         ej_ctrl  <= port4_co;
         ej_data  <= port4_do;
      end
   end

endmodule

// File: tb/tb_inject_ctrl.sv
// Directed vector table plus hand sequences and a queue-model random run for inject_ctrl.
`ifndef DATA_W
`define DATA_W    16
`define CONTROL_W 17
`define VALID_F   0
`define DEST_F    4:1
`define SRC_F     8:5
`define AGE_F     16:9
`endif

module tb_inject_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        enq_valid, enq_ready, port4_ready;
   logic [3:0]  enq_dest;
   logic [15:0] enq_data, port4_di, port4_do, ej_data;
   logic [16:0] port4_ci, port4_co, ej_ctrl;
   logic        ej_valid, starved;
   logic [15:0] inj_count;

   int checks = 0;
   int errors = 0;

   inject_ctrl dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_dest(enq_dest), .enq_data(enq_data),
      .port4_ready(port4_ready), .port4_ci(port4_ci), .port4_di(port4_di),
      .port4_co(port4_co), .port4_do(port4_do),
      .ej_valid(ej_valid), .ej_ctrl(ej_ctrl), .ej_data(ej_data),
      .starved(starved), .inj_count(inj_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ev;
      logic [3:0]  ed;
      logic [15:0] edata;
      logic        rdy;
      logic [16:0] co;
      logic [15:0] dout;
      logic [16:0] x_ci;
      logic [15:0] x_di;
      logic        x_er;
      logic        x_ejv;
      logic [16:0] x_ejc;
      logic [15:0] x_ejd;
      logic [15:0] x_inj;
   } vec_t;

   typedef struct {
      logic [3:0]  d;
      logic [15:0] x;
   } ent_t;

   function automatic logic [16:0] mk(input logic v, input logic [3:0] d, input logic [3:0] s,
                                      input logic [7:0] a);
      return {a, s, d, v};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ev, input logic [3:0] d, input logic [15:0] x, input logic rdy);
      enq_valid = ev; enq_dest = d; enq_data = x; port4_ready = rdy;
   endtask

   vec_t tbl[8];
   ent_t q[$];
   logic [7:0]  mwait;
   logic [15:0] minj;
   logic [16:0] x_ci;
   logic [15:0] x_di;
   logic        m_empty, m_fire, m_enq;

   initial begin
      tbl[0] = '{1'b1, 4'h3, 16'hA5A5, 1'b1, 17'h0, 16'h0,
                 17'h0, 16'h0, 1'b1, 1'b0, 17'h0, 16'h0, 16'd0};
      tbl[1] = '{1'b0, 4'h0, 16'h0, 1'b1, mk(1'b1, 4'h5, 4'h9, 8'd7), 16'h1234,
                 mk(1'b1, 4'h3, 4'h5, 8'd0), 16'hA5A5, 1'b1, 1'b0, 17'h0, 16'h0, 16'd0};
      tbl[2] = '{1'b0, 4'h0, 16'h0, 1'b1, 17'h0, 16'h0,
                 17'h0, 16'h0, 1'b1, 1'b1, mk(1'b1, 4'h5, 4'h9, 8'd7), 16'h1234, 16'd1};
      tbl[3] = '{1'b0, 4'h0, 16'h0, 1'b0, 17'h000AA, 16'hBEEF,
                 17'h0, 16'h0, 1'b1, 1'b0, 17'h0, 16'h0, 16'd1};
      tbl[4] = '{1'b1, 4'h7, 16'h1111, 1'b0, 17'h0, 16'h0,
                 17'h0, 16'h0, 1'b1, 1'b0, 17'h000AA, 16'hBEEF, 16'd1};
      tbl[5] = '{1'b0, 4'h0, 16'h0, 1'b0, 17'h0, 16'h0,
                 17'h0, 16'h1111, 1'b1, 1'b0, 17'h0, 16'h0, 16'd1};
      tbl[6] = '{1'b0, 4'h0, 16'h0, 1'b1, 17'h0, 16'h0,
                 mk(1'b1, 4'h7, 4'h5, 8'd1), 16'h1111, 1'b1, 1'b0, 17'h0, 16'h0, 16'd1};
      tbl[7] = '{1'b0, 4'h0, 16'h0, 1'b0, 17'h0, 16'h0,
                 17'h0, 16'h0, 1'b1, 1'b0, 17'h0, 16'h0, 16'd2};

      rst = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 1'b0);
      port4_co = '0; port4_do = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ci", port4_ci, 17'h0);
      chk("rst_enq_ready", enq_ready, 1);
      chk("rst_ej_valid", ej_valid, 0);
      chk("rst_ej_ctrl", ej_ctrl, 17'h0);
      chk("rst_starved", starved, 0);
      chk("rst_inj_count", inj_count, 0);
      rst = 1'b1;
      @(negedge clk);

      // table: inputs applied before the edge, outputs checked in the same cycle
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].ev, tbl[i].ed, tbl[i].edata, tbl[i].rdy);
         port4_co = tbl[i].co; port4_do = tbl[i].dout;
         #1;
         chk($sformatf("vec%0d_ci", i), port4_ci, tbl[i].x_ci);
         chk($sformatf("vec%0d_di", i), port4_di, tbl[i].x_di);
         chk($sformatf("vec%0d_enq_ready", i), enq_ready, tbl[i].x_er);
         chk($sformatf("vec%0d_ej_valid", i), ej_valid, tbl[i].x_ejv);
         chk($sformatf("vec%0d_ej_ctrl", i), ej_ctrl, tbl[i].x_ejc);
         chk($sformatf("vec%0d_ej_data", i), ej_data, tbl[i].x_ejd);
         chk($sformatf("vec%0d_inj_count", i), inj_count, tbl[i].x_inj);
         @(negedge clk);
      end
      port4_co = '0; port4_do = '0;

      // full FIFO and backpressure
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'(i + 1), 16'(16'h10 + i), 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 4'h0, 16'h0, 1'b0);
      #1;
      chk("full_enq_ready", enq_ready, 0);
      chk("full_ci_blocked", port4_ci, 17'h0);
      port4_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("full_ci%0d", i), port4_ci, mk(1'b1, 4'(i + 1), 4'h5, (i == 0) ? 8'd3 : 8'd0));
         chk($sformatf("full_di%0d", i), port4_di, 16'(16'h10 + i));
         if (i == 0) chk("full_fire_enq_ready", enq_ready, 0);
         if (i == 1) chk("after_pop_enq_ready", enq_ready, 1);
         @(negedge clk);
      end
      port4_ready = 1'b0;
      #1;
      chk("full_drained_ci", port4_ci, 17'h0);
      chk("full_inj_count", inj_count, 6);

      // age and starvation
      @(negedge clk);
      drive(1'b1, 4'h2, 16'h2222, 1'b0);
      @(negedge clk);
      enq_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         if (k == 16) chk("starve_c16", starved, 0);
         if (k == 17) chk("starve_c17", starved, 1);
         @(negedge clk);
      end
      port4_ready = 1'b1;
      #1;
      chk("starve_age_ci", port4_ci, mk(1'b1, 4'h2, 4'h5, 8'd20));
      chk("starve_still", starved, 1);
      @(negedge clk);
      port4_ready = 1'b0;
      #1;
      chk("starve_clear", starved, 0);
      chk("starve_inj_count", inj_count, 7);

      // simultaneous enqueue and fire at occupancy 2
      drive(1'b1, 4'h8, 16'hAAAA, 1'b0); @(negedge clk);
      drive(1'b1, 4'h9, 16'hBBBB, 1'b0); @(negedge clk);
      drive(1'b1, 4'hA, 16'hCCCC, 1'b1);
      #1;
      chk("sim_ci_a", port4_ci, mk(1'b1, 4'h8, 4'h5, 8'd1));
      chk("sim_enq_ready", enq_ready, 1);
      @(negedge clk);
      drive(1'b0, 4'h0, 16'h0, 1'b1);
      #1;
      chk("sim_ci_b", port4_ci, mk(1'b1, 4'h9, 4'h5, 8'd0));
      chk("sim_di_b", port4_di, 16'hBBBB);
      @(negedge clk);
      #1;
      chk("sim_ci_c", port4_ci, mk(1'b1, 4'hA, 4'h5, 8'd0));
      chk("sim_di_c", port4_di, 16'hCCCC);
      @(negedge clk);
      #1;
      chk("sim_empty_ci", port4_ci, 17'h0);
      chk("sim_inj_count", inj_count, 10);

      // random enqueue/ready patterns against a reference queue
      mwait = '0; minj = 16'd10;
      for (int n = 0; n < 100; n++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
         #1;
         m_empty = (q.size() == 0);
         m_fire  = !m_empty && port4_ready;
         m_enq   = enq_valid && (q.size() < 4);
         x_ci    = m_fire ? mk(1'b1, q[0].d, 4'h5, mwait) : 17'h0;
         x_di    = m_empty ? 16'h0 : q[0].x;
         chk($sformatf("rnd%0d_ci", n), port4_ci, x_ci);
         chk($sformatf("rnd%0d_di", n), port4_di, x_di);
         chk($sformatf("rnd%0d_enq_ready", n), enq_ready, (q.size() < 4));
         if (m_empty || m_fire) mwait = '0;
         else if (mwait != 8'hFF) mwait = mwait + 8'd1;
         if (m_fire) begin
            void'(q.pop_front());
            minj = minj + 16'd1;
         end
         if (m_enq) q.push_back('{enq_dest, enq_data});
         @(negedge clk);
      end
      #1;
      chk("rnd_inj_count", inj_count, minj);

      // reset mid-run with three flits queued and the head starved
      drive(1'b0, 4'h0, 16'h0, 1'b1);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 11), 16'(16'hD0 + i), 1'b0);
         @(negedge clk);
      end
      enq_valid = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("pre_rst_starved", starved, 1);
      rst = 1'b0;
      port4_ready = 1'b1;
      #1;
      chk("mid_rst_ci", port4_ci, 17'h0);
      chk("mid_rst_starved", starved, 0);
      chk("mid_rst_enq_ready", enq_ready, 1);
      chk("mid_rst_inj_count", inj_count, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("post_rst_ci%0d", i), port4_ci, 17'h0);
         chk($sformatf("post_rst_di%0d", i), port4_di, 16'h0);
         @(negedge clk);
      end

      // inj_count wrap: first edge only enqueues, every later edge fires
      drive(1'b1, 4'h1, 16'h0005, 1'b1);
      repeat (65536) @(negedge clk);
      #1;
      chk("inj_count_max", inj_count, 16'hFFFF);
      @(negedge clk);
      #1;
      chk("inj_count_wrap", inj_count, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
